// File: rtl/cache_pkg.sv
// Shared types for the cache memory-side sequencer: FSM states, write-buffer
// entry layout and block alignment helper.
package cache_pkg;

    localparam int unsigned CACHE_ADDR_BITS = 32;
    localparam int unsigned CACHE_DATA_BITS = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_REQ,
        S_WAIT,
        S_DONE
    } ctrl_state_t;

    typedef struct packed {
        logic [CACHE_ADDR_BITS-1:0] addr;
        logic [CACHE_DATA_BITS-1:0] data;
    } wbuf_entry_t;

    // block_bits is a power of two, so clearing the low bits aligns the address
    function automatic logic [CACHE_ADDR_BITS-1:0] block_base(
        input logic [CACHE_ADDR_BITS-1:0] addr,
        input int unsigned                block_bits
    );
        logic [CACHE_ADDR_BITS-1:0] mask;
        mask = CACHE_ADDR_BITS'(block_bits - 1);
        return addr & ~mask;
    endfunction

endpackage

// File: rtl/cache_wbuf.sv
// Write-through buffer: synchronous FIFO of address/data entries, drained in
// order towards memory.
module cache_wbuf
    import cache_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push,
    input  wbuf_entry_t push_entry,
    input  logic        pop,
    output logic        full,
    output logic        empty,
    output logic        one_left,
    output wbuf_entry_t head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    wbuf_entry_t        store_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                store_q[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                store_q[wr_ptr] <= push_entry;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + (PTR_W+1)'(1);
            end else if (pop && !push) begin
                count <= count - (PTR_W+1)'(1);
            end
        end
    end

    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign one_left = (count == (PTR_W+1)'(1));
    assign head     = store_q[rd_ptr];

endmodule

// File: rtl/cache_mem_ctrl.sv
// Memory-side sequencer: drains buffered write-throughs, then bursts the word
// reads of a missed block and presents the assembled block for one cycle.
module cache_mem_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned RAM_ADDRESS_BITS = CACHE_ADDR_BITS,
    parameter int unsigned DATA_BITS        = CACHE_DATA_BITS,
    parameter int unsigned BLOCK_BITS       = 2,
    parameter int unsigned WBUF_DEPTH       = 4
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [RAM_ADDRESS_BITS-1:0]           prop_address,
    input  logic                                  prop_read_en,
    input  logic [DATA_BITS-1:0]                  prop_write_data,
    input  logic                                  prop_write_en,
    output logic                                  busy,
    output logic                                  ram_valid,
    output logic [BLOCK_BITS-1:0][DATA_BITS-1:0]  ram_data,
    output logic [RAM_ADDRESS_BITS-1:0]           mem_address,
    output logic                                  mem_read_en,
    output logic                                  mem_write_en,
    output logic [DATA_BITS-1:0]                  mem_write_data,
    input  logic                                  mem_ready,
    input  logic                                  mem_rvalid,
    input  logic [DATA_BITS-1:0]                  mem_rdata
);

    localparam int unsigned CNT_W = (BLOCK_BITS > 1) ? $clog2(BLOCK_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLOCK_BITS - 1);

    ctrl_state_t                 state, state_nx;
    logic [RAM_ADDRESS_BITS-1:0] base;
    logic [CNT_W-1:0]            req_cnt;
    logic [CNT_W-1:0]            rsp_cnt;

    logic        wbuf_push, wbuf_pop, wbuf_full, wbuf_empty, wbuf_one;
    wbuf_entry_t wbuf_in, wbuf_head;
    logic        rd_accept;

    assign busy      = (state != S_IDLE) | wbuf_full;
    assign rd_accept = prop_read_en & ~busy;
    assign wbuf_push = prop_write_en & ~busy;
    assign wbuf_pop  = mem_write_en & mem_ready;
    assign ram_valid = (state == S_DONE);

    always_comb begin
        wbuf_in      = '0;
        wbuf_in.addr = CACHE_ADDR_BITS'(prop_address);
        wbuf_in.data = CACHE_DATA_BITS'(prop_write_data);
    end

    cache_wbuf #(
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (wbuf_push),
        .push_entry (wbuf_in),
        .pop        (wbuf_pop),
        .full       (wbuf_full),
        .empty      (wbuf_empty),
        .one_left   (wbuf_one),
        .head       (wbuf_head)
    );

    // Memory requests decode purely from registered state, so they stay stable until accepted
    always_comb begin
        mem_read_en    = (state == S_REQ);
        mem_write_en   = ((state == S_IDLE) || (state == S_DRAIN)) && !wbuf_empty;
        mem_address    = '0;
        mem_write_data = '0;
        if (mem_read_en) begin
            mem_address = base | RAM_ADDRESS_BITS'(req_cnt);
        end else if (mem_write_en) begin
            mem_address    = RAM_ADDRESS_BITS'(wbuf_head.addr);
            mem_write_data = DATA_BITS'(wbuf_head.data);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (rd_accept) state_nx = S_DRAIN;
            S_DRAIN: if (wbuf_empty || (wbuf_pop && wbuf_one)) state_nx = S_REQ;
            S_REQ: begin
                if (mem_rvalid && rsp_cnt == LAST_BEAT) begin
                    state_nx = S_DONE;
                end else if (mem_ready && req_cnt == LAST_BEAT) begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT:  if (mem_rvalid && rsp_cnt == LAST_BEAT) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            base     <= '0;
            req_cnt  <= '0;
            rsp_cnt  <= '0;
            ram_data <= '0;
        end else begin
            state <= state_nx;
            if (rd_accept) begin
                base    <= RAM_ADDRESS_BITS'(block_base(CACHE_ADDR_BITS'(prop_address), BLOCK_BITS));
                req_cnt <= '0;
                rsp_cnt <= '0;
            end
            if (state == S_REQ && mem_ready) begin
                req_cnt <= req_cnt + CNT_W'(1);
            end
            if ((state == S_REQ || state == S_WAIT) && mem_rvalid) begin
                ram_data[rsp_cnt] <= mem_rdata;
                rsp_cnt           <= rsp_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Scoreboard bench for cache_mem_ctrl: directed stimulus pushes expected memory
// transactions and refill blocks; a negedge monitor pops and compares them.
module tb_cache_mem_ctrl;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [31:0]        prop_address = '0;
    logic               prop_read_en = 1'b0;
    logic [31:0]        prop_write_data = '0;
    logic               prop_write_en = 1'b0;
    logic               busy;
    logic               ram_valid;
    logic [1:0][31:0]   ram_data;
    logic [31:0]        mem_address;
    logic               mem_read_en;
    logic               mem_write_en;
    logic [31:0]        mem_write_data;
    logic               mem_ready = 1'b1;
    logic               mem_rvalid = 1'b0;
    logic [31:0]        mem_rdata = '0;

    cache_mem_ctrl #(
        .RAM_ADDRESS_BITS (32),
        .DATA_BITS        (32),
        .BLOCK_BITS       (2),
        .WBUF_DEPTH       (4)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .prop_address    (prop_address),
        .prop_read_en    (prop_read_en),
        .prop_write_data (prop_write_data),
        .prop_write_en   (prop_write_en),
        .busy            (busy),
        .ram_valid       (ram_valid),
        .ram_data        (ram_data),
        .mem_address     (mem_address),
        .mem_read_en     (mem_read_en),
        .mem_write_en    (mem_write_en),
        .mem_write_data  (mem_write_data),
        .mem_ready       (mem_ready),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata)
    );

    always #5 clk = ~clk;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    int unsigned cyc = 0;
    int unsigned n_refill = 0;
    int unsigned n_rd_acc = 0;

    typedef struct packed {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    typedef struct packed {
        logic [31:0] due;
        logic [31:0] data;
    } rsp_t;

    txn_t             exp_txn [$];
    logic [1:0][31:0] exp_blk [$];
    rsp_t             rsp_q [$];
    logic [31:0]      mem_model [logic [31:0]];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name, input string msg);
        n_total++;
        $display("FAIL %s: %s", name, msg);
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {16'hD000, a[15:0]};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: responses come back two cycles after the accepting edge
    always @(posedge clk) begin
        #1;
        if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rsp_q[0].data;
            void'(rsp_q.pop_front());
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end
    end

    logic        stall_pend = 1'b0;
    logic [65:0] stall_snap = '0;

    always @(negedge clk) begin
        if (!reset_n) begin
            stall_pend = 1'b0;
        end else begin
            txn_t t;
            if (mem_read_en || mem_write_en)
                check("rd_wr_exclusive", {127'(0), mem_read_en & mem_write_en}, '0);
            if (stall_pend)
                check("stall_hold", {mem_read_en, mem_write_en, mem_address, mem_write_data}, stall_snap);
            stall_pend = 1'b0;
            if ((mem_read_en || mem_write_en) && !mem_ready) begin
                stall_pend = 1'b1;
                stall_snap = {mem_read_en, mem_write_en, mem_address, mem_write_data};
            end
            if ((mem_read_en || mem_write_en) && mem_ready) begin
                if (exp_txn.size() == 0) begin
                    fail_now("txn", $sformatf("unexpected wr=%0b addr=%0h", mem_write_en, mem_address));
                end else begin
                    t = exp_txn.pop_front();
                    check("txn", {mem_write_en, mem_address, mem_write_en ? mem_write_data : 32'h0}, t);
                end
                if (mem_write_en) mem_model[mem_address] = mem_write_data;
                if (mem_read_en) begin
                    rsp_q.push_back('{cyc + 2, mem_read(mem_address)});
                    n_rd_acc++;
                end
            end
            if (ram_valid) begin
                n_refill++;
                if (exp_blk.size() == 0) fail_now("refill", $sformatf("unexpected ram_valid data=%0h", ram_data));
                else check("refill", ram_data, exp_blk.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until the DUT is not busy at the accepting edge
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
        bit ok = 0;
        prop_read_en    = rd;
        prop_write_en   = wr;
        prop_address    = addr;
        prop_write_data = data;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1;
        end
        if (!ok) fail_now("req_accept", "request never accepted");
        tick();
        prop_read_en  = 1'b0;
        prop_write_en = 1'b0;
    endtask

    task automatic wait_refill(input int unsigned target);
        for (int i = 0; i < 200 && n_refill < target; i++) tick();
        if (n_refill < target) fail_now("refill_timeout", $sformatf("refills=%0d wanted %0d", n_refill, target));
    endtask

    initial begin
        // Reset held with random inputs
        for (int i = 0; i < 6; i++) begin
            prop_address    = $urandom;
            prop_write_data = $urandom;
            prop_read_en    = 1'($urandom);
            prop_write_en   = 1'($urandom);
            mem_ready       = 1'($urandom);
            @(negedge clk);
            check("rst_busy", {127'(0), busy}, '0);
            check("rst_ram_valid", {127'(0), ram_valid}, '0);
            check("rst_mem_en", {126'(0), mem_read_en, mem_write_en}, '0);
            check("rst_ram_data", ram_data, '0);
            tick();
        end
        prop_read_en  = 1'b0;
        prop_write_en = 1'b0;
        mem_ready     = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();

        mem_model[32'h10] = 32'hA0;
        mem_model[32'h11] = 32'hA1;

        // Basic refills
        exp_txn.push_back('{1'b0, 32'h10, 32'h0});
        exp_txn.push_back('{1'b0, 32'h11, 32'h0});
        exp_blk.push_back({32'hA1, 32'hA0});
        do_req(1'b1, 1'b0, 32'h11, 32'h0);
        wait_refill(1);
        exp_txn.push_back('{1'b0, 32'h5000, 32'h0});
        exp_txn.push_back('{1'b0, 32'h5001, 32'h0});
        exp_blk.push_back({32'hD0005001, 32'hD0005000});
        do_req(1'b1, 1'b0, 32'h5001, 32'h0);
        wait_refill(2);
        tick();

        // Write buffer fills while memory stalls
        mem_ready = 1'b0;
        for (int i = 1; i <= 5; i++)
            exp_txn.push_back('{1'b1, 32'(i) << 16, 32'h45});
        for (int i = 1; i <= 4; i++)
            do_req(1'b0, 1'b1, 32'(i) << 16, 32'h45);
        prop_write_en   = 1'b1;
        prop_address    = 32'h50000;
        prop_write_data = 32'h45;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_busy", {127'(0), busy}, 128'(1));
            tick();
        end
        mem_ready = 1'b1;
        tick();
        check("busy_after_pop", {127'(0), busy}, '0);
        tick();
        prop_write_en = 1'b0;
        for (int i = 0; i < 100 && exp_txn.size() > 0; i++) tick();

        // Write and read in the same cycle: the write reaches memory first
        exp_txn.push_back('{1'b1, 32'h10, 32'h55});
        exp_txn.push_back('{1'b0, 32'h10, 32'h0});
        exp_txn.push_back('{1'b0, 32'h11, 32'h0});
        exp_blk.push_back({32'hA1, 32'h55});
        do_req(1'b1, 1'b1, 32'h10, 32'h55);
        wait_refill(3);
        tick();

        // Toggling mem_ready through the burst
        exp_txn.push_back('{1'b0, 32'h122, 32'h0});
        exp_txn.push_back('{1'b0, 32'h123, 32'h0});
        exp_blk.push_back({32'hD0000123, 32'hD0000122});
        do_req(1'b1, 1'b0, 32'h123, 32'h0);
        mem_ready = 1'b0;
        for (int i = 0; i < 200 && n_refill < 4; i++) begin
            tick();
            mem_ready = ~mem_ready;
        end
        if (n_refill < 4) fail_now("refill_timeout", "toggled-ready refill missing");
        mem_ready = 1'b1;
        tick();

        // Reset while waiting for read data; late responses must be ignored
        exp_txn.push_back('{1'b0, 32'h20, 32'h0});
        exp_txn.push_back('{1'b0, 32'h21, 32'h0});
        begin
            int unsigned acc0;
            acc0 = n_rd_acc;
            do_req(1'b1, 1'b0, 32'h21, 32'h0);
            for (int i = 0; i < 100 && n_rd_acc < acc0 + 2; i++) tick();
            if (n_rd_acc < acc0 + 2) fail_now("read_issue", "burst reads not issued");
        end
        reset_n = 1'b0;
        #1;
        check("midrst_busy", {127'(0), busy}, '0);
        check("midrst_rd_en", {127'(0), mem_read_en}, '0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("late_rsp_refills", 128'(n_refill), 128'(4));
        check("late_rsp_ram_data", ram_data, '0);
        check("late_rsp_busy", {127'(0), busy}, '0);

        check("txn_queue_empty", 128'(exp_txn.size()), '0);
        check("blk_queue_empty", 128'(exp_blk.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
